// File: rtl/vpe_vadd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// vpe_vadd_arbiter: round-robin/lockable arbiter feeding a pipelined vector adder,
// with a tag pipeline that routes each result back to its requester. Rev 1.0
module vpe_vadd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADD_LAT = 2,
  parameter int LOCK_TO = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arb_en_i,
  input  logic [NUM_REQ-1:0]       req_v_i,
  input  logic [256*NUM_REQ-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]       req_relu_i,
  input  logic [5*NUM_REQ-1:0]     req_rf_idx_i,
  input  logic [2*NUM_REQ-1:0]     req_rf_mux_i,
  input  logic [NUM_REQ-1:0]       req_lock_i,
  output logic [NUM_REQ-1:0]       req_rdy_o,
  output logic [255:0]             add_data_o,
  output logic                     add_data_v_o,
  output logic                     add_en_relu_o,
  output logic [4:0]               add_rf_idx_o,
  output logic [1:0]               add_rf_mux_o,
  input  logic [63:0]              add_res_i,
  input  logic                     add_res_v_i,
  output logic [63:0]              rsp_data_o,
  output logic [NUM_REQ-1:0]       rsp_v_o,
  output logic                     busy_o,
  output logic                     err_orphan_o,
  output logic [15:0]              beat_cnt_o
);

  localparam int CNT_W = $clog2(LOCK_TO + 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e             state_q;
  logic [1:0]         ptr_q;
  logic [1:0]         owner_q;
  logic [CNT_W-1:0]   idle_cnt_q;

  logic [NUM_REQ-1:0] gnt_oh;
  logic [1:0]         gnt_idx;
  logic [1:0]         cand;
  logic               found;
  logic               accept;

  logic [255:0]       data_a   [NUM_REQ];
  logic [4:0]         rf_idx_a [NUM_REQ];
  logic [1:0]         rf_mux_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_a[g]   = req_data_i[256*g +: 256];
    assign rf_idx_a[g] = req_rf_idx_i[5*g +: 5];
    assign rf_mux_a[g] = req_rf_mux_i[2*g +: 2];
  end

  logic [255:0]       add_data_q;
  logic               add_data_v_q;
  logic               add_en_relu_q;
  logic [4:0]         add_rf_idx_q;
  logic [1:0]         add_rf_mux_q;
  logic [1:0]         add_id_q;
  logic               tag_v_q  [ADD_LAT];
  logic [1:0]         tag_id_q [ADD_LAT];
  logic               err_orphan_q;
  logic [15:0]        beat_cnt_q;
  logic               tag_any;

  // A locked owner is the only eligible requester; otherwise rotate from ptr.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    if (arb_en_i) begin
      if (state_q == ST_LOCKED) begin
        if (req_v_i[owner_q]) begin
          gnt_oh[owner_q] = 1'b1;
          gnt_idx         = owner_q;
        end
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          cand = ptr_q + 2'(k);
          if (!found && req_v_i[cand]) begin
            found         = 1'b1;
            gnt_idx       = cand;
            gnt_oh[cand]  = 1'b1;
          end
        end
      end
    end
  end

  assign accept    = |gnt_oh;
  assign req_rdy_o = gnt_oh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      idle_cnt_q <= '0;
    end else if (accept) begin
      ptr_q      <= gnt_idx + 2'd1;
      idle_cnt_q <= '0;
      if (req_lock_i[gnt_idx]) begin
        state_q <= ST_LOCKED;
        owner_q <= gnt_idx;
      end else begin
        state_q <= ST_IDLE;
      end
    end else if (state_q == ST_LOCKED && arb_en_i && !req_v_i[owner_q]) begin
      // Timeout counts only while arbitration is enabled so a paused lock is kept.
      if (idle_cnt_q == CNT_W'(LOCK_TO - 1)) begin
        state_q    <= ST_IDLE;
        idle_cnt_q <= '0;
        ptr_q      <= owner_q + 2'd1;
      end else begin
        idle_cnt_q <= idle_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_data_v_q  <= 1'b0;
      add_en_relu_q <= 1'b0;
      err_orphan_q  <= 1'b0;
      beat_cnt_q    <= '0;
      for (int i = 0; i < ADD_LAT; i++) tag_v_q[i] <= 1'b0;
    end else begin
      add_data_v_q  <= accept;
      add_en_relu_q <= accept & req_relu_i[gnt_idx];
      if (accept) beat_cnt_q <= beat_cnt_q + 16'd1;
      tag_v_q[0] <= add_data_v_q;
      for (int i = 1; i < ADD_LAT; i++) tag_v_q[i] <= tag_v_q[i-1];
      if (add_res_v_i && !tag_v_q[ADD_LAT-1]) err_orphan_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      add_data_q   <= data_a[gnt_idx];
      add_rf_idx_q <= rf_idx_a[gnt_idx];
      add_rf_mux_q <= rf_mux_a[gnt_idx];
      add_id_q     <= gnt_idx;
    end
    tag_id_q[0] <= add_id_q;
    for (int i = 1; i < ADD_LAT; i++) tag_id_q[i] <= tag_id_q[i-1];
  end

  always_comb begin
    tag_any = 1'b0;
    for (int i = 0; i < ADD_LAT; i++) tag_any = tag_any | tag_v_q[i];
    rsp_v_o = '0;
    if (add_res_v_i && tag_v_q[ADD_LAT-1]) rsp_v_o[tag_id_q[ADD_LAT-1]] = 1'b1;
  end

  assign rsp_data_o    = add_res_i;
  assign add_data_o    = add_data_q;
  assign add_data_v_o  = add_data_v_q;
  assign add_en_relu_o = add_en_relu_q;
  assign add_rf_idx_o  = add_rf_idx_q;
  assign add_rf_mux_o  = add_rf_mux_q;
  assign err_orphan_o  = err_orphan_q;
  assign beat_cnt_o    = beat_cnt_q;
  assign busy_o        = tag_any | add_data_v_q | (state_q == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_vpe_vadd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// tb_vpe_vadd_arbiter: scoreboard bench with a 2-stage adder model. Rev 1.0
module tb_vpe_vadd_arbiter;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arb_en = 1'b0;
  logic [3:0]    req_v = '0;
  logic [1023:0] req_data = '0;
  logic [3:0]    req_relu = '0;
  logic [19:0]   req_rf_idx = '0;
  logic [7:0]    req_rf_mux = '0;
  logic [3:0]    req_lock = '0;
  logic [3:0]    req_rdy;
  logic [255:0]  add_data;
  logic          add_data_v, add_en_relu;
  logic [4:0]    add_rf_idx;
  logic [1:0]    add_rf_mux;
  logic [63:0]   add_res;
  logic          add_res_v;
  logic [63:0]   rsp_data;
  logic [3:0]    rsp_v;
  logic          busy, err_orphan;
  logic [15:0]   beat_cnt;

  logic          p0_v = 1'b0, p1_v = 1'b0, inj = 1'b0;
  logic [63:0]   p0_d = '0, p1_d = '0;
  logic [63:0]   last_d;
  int            cyc = 0;
  int            n_chk = 0;
  int            n_fail = 0;
  bit            bulk = 1'b0;

  typedef struct {
    logic [3:0]  oh;
    logic [63:0] d;
    int          c;
  } sb_t;
  sb_t sb[$];

  vpe_vadd_arbiter #(.NUM_REQ(4), .ADD_LAT(2), .LOCK_TO(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .arb_en_i     (arb_en),
    .req_v_i      (req_v),
    .req_data_i   (req_data),
    .req_relu_i   (req_relu),
    .req_rf_idx_i (req_rf_idx),
    .req_rf_mux_i (req_rf_mux),
    .req_lock_i   (req_lock),
    .req_rdy_o    (req_rdy),
    .add_data_o   (add_data),
    .add_data_v_o (add_data_v),
    .add_en_relu_o(add_en_relu),
    .add_rf_idx_o (add_rf_idx),
    .add_rf_mux_o (add_rf_mux),
    .add_res_i    (add_res),
    .add_res_v_i  (add_res_v),
    .rsp_data_o   (rsp_data),
    .rsp_v_o      (rsp_v),
    .busy_o       (busy),
    .err_orphan_o (err_orphan),
    .beat_cnt_o   (beat_cnt)
  );

  always #5 clk = ~clk;

  // Adder model: two-cycle pass-through of the low 64 bits; inj forces a stray result.
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    p0_v <= add_data_v;
    p0_d <= add_data[63:0];
    p1_v <= p0_v;
    p1_d <= p0_d;
  end
  assign add_res_v = p1_v | inj;
  assign add_res   = p1_d;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!bulk && !rst && rsp_v != 4'b0) begin
      sb_t e;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_v), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_v", 64'(rsp_v), 64'(e.oh));
        chk("rsp_data", rsp_data, e.d);
        chk("rsp_latency", 64'(cyc - e.c), 64'd3);
      end
    end
  end

  // One cycle: fresh operand data, check the grant, record the expected result.
  task automatic step(input logic [3:0] want);
    int idx;
    for (int i = 0; i < 4; i++) req_data[256*i +: 64] = {32'(cyc), 32'hA5A5_0000 | 32'(i)};
    @(negedge clk);
    chk("gnt", 64'(req_rdy), 64'(want));
    if (want != 4'b0) begin
      idx = (want == 4'b0001) ? 0 : (want == 4'b0010) ? 1 : (want == 4'b0100) ? 2 : 3;
      sb.push_back('{want, req_data[256*idx +: 64], cyc});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    arb_en = 1'b1;
    @(negedge clk);
    chk("rst_rdy", 64'(req_rdy), 64'd0);
    chk("rst_add_v", 64'(add_data_v), 64'd0);
    chk("rst_relu", 64'(add_en_relu), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err_orphan), 64'd0);
    chk("rst_cnt", 64'(beat_cnt), 64'd0);
    chk("rst_rsp_v", 64'(rsp_v), 64'd0);
    @(posedge clk);
    #1;

    // All requesters valid: strict rotation starting at 0.
    req_v = 4'hF;
    for (int i = 0; i < 8; i++) step(4'b0001 << (i % 4));
    req_v = 4'h0;
    repeat (5) step(4'b0);
    chk("cnt_rr", 64'(beat_cnt), 64'd8);
    chk("drain_rr", 64'(sb.size()), 64'd0);

    // Requester 2 holds the grant for three beats against 0 and 1.
    req_v = 4'b0010;
    step(4'b0010);
    req_v = 4'b0111;
    req_lock = 4'b0100;
    step(4'b0100);
    chk("busy_lock", 64'(busy), 64'd1);
    step(4'b0100);
    req_lock = 4'b0;
    step(4'b0100);
    req_v = 4'b0011;
    step(4'b0001);
    req_v = 4'b0;
    repeat (4) step(4'b0);

    // Requester 1 locks then goes quiet; requester 3 waits out the timeout.
    req_v = 4'b0010;
    req_lock = 4'b0010;
    step(4'b0010);
    req_lock = 4'b0;
    req_v = 4'b1000;
    for (int i = 0; i < 15; i++) step(4'b0);
    chk("busy_locked_idle", 64'(busy), 64'd1);
    step(4'b0);
    step(4'b1000);
    req_v = 4'b0;
    repeat (4) step(4'b0);

    // Disable arbitration with two beats in flight.
    req_v = 4'b0011;
    step(4'b0001);
    step(4'b0010);
    arb_en = 1'b0;
    req_v = 4'hF;
    chk("busy_inflight", 64'(busy), 64'd1);
    repeat (4) step(4'b0);
    chk("busy_done", 64'(busy), 64'd0);
    chk("drain_dis", 64'(sb.size()), 64'd0);
    arb_en = 1'b1;
    req_v = 4'b0;

    // Stray result with an empty tag pipeline.
    inj = 1'b1;
    @(negedge clk);
    chk("orphan_rsp_v", 64'(rsp_v), 64'd0);
    @(posedge clk);
    #1 inj = 1'b0;
    chk("orphan_set", 64'(err_orphan), 64'd1);
    repeat (3) step(4'b0);
    chk("orphan_sticky", 64'(err_orphan), 64'd1);
    rst = 1'b1;
    #2 rst = 1'b0;
    chk("orphan_clr", 64'(err_orphan), 64'd0);

    // Reset with a beat inside the adder: its late result is an orphan.
    req_v = 4'b0001;
    step(4'b0001);
    req_v = 4'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    chk("rstflight_rsp_v", 64'(rsp_v), 64'd0);
    @(posedge clk);
    #1;
    chk("rstflight_err", 64'(err_orphan), 64'd1);
    rst = 1'b1;
    #2 rst = 1'b0;

    // Sideband fields travel with the beat.
    req_rf_idx = {5'd9, 5'd4, 5'd3, 5'd17};
    req_rf_mux = {2'd1, 2'd3, 2'd0, 2'd2};
    req_relu   = 4'b0001;
    req_v      = 4'b0001;
    step(4'b0001);
    req_v  = 4'b0;
    last_d = sb[sb.size()-1].d;
    @(negedge clk);
    chk("sb_add_v", 64'(add_data_v), 64'd1);
    chk("sb_rf_idx", 64'(add_rf_idx), 64'd17);
    chk("sb_rf_mux", 64'(add_rf_mux), 64'd2);
    chk("sb_relu", 64'(add_en_relu), 64'd1);
    chk("sb_data", add_data[63:0], last_d);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("sb_add_v_off", 64'(add_data_v), 64'd0);
    chk("sb_relu_off", 64'(add_en_relu), 64'd0);
    @(posedge clk);
    #1;
    repeat (3) step(4'b0);
    chk("drain_sb", 64'(sb.size()), 64'd0);

    // 65536 accepted beats wrap the counter to zero.
    rst = 1'b1;
    #2 rst = 1'b0;
    bulk  = 1'b1;
    req_v = 4'hF;
    repeat (65536) @(posedge clk);
    #1 req_v = 4'b0;
    chk("cnt_wrap", 64'(beat_cnt), 64'd0);
    repeat (6) @(posedge clk);
    #1 bulk = 1'b0;
    req_v = 4'b0100;
    step(4'b0100);
    req_v = 4'b0;
    repeat (4) step(4'b0);
    chk("cnt_after_wrap", 64'(beat_cnt), 64'd1);
    chk("final_drain", 64'(sb.size()), 64'd0);
    chk("final_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
